// File: rtl/arm_pipe_pkg.sv
// arm_pipe_pkg
//   Shared pipeline types for the ARM core stage registers (id_exe, exe_mem, mem_wb).
//   WORD_LENGTH : width of ALU result / store data
//   REG_ADDR_W  : width of a register index (R0..R15)
//   exe_mem_payload_t : everything EXE hands to MEM (flags NZCV are not carried)
package arm_pipe_pkg;

  localparam int WORD_LENGTH = 32;
  localparam int REG_ADDR_W  = 4;

  typedef struct packed {
    logic                   wb_en;
    logic                   mem_r_en;
    logic                   mem_w_en;
    logic [WORD_LENGTH-1:0] alu_res;
    logic [WORD_LENGTH-1:0] val_rm;
    logic [REG_ADDR_W-1:0]  dest;
  } exe_mem_payload_t;

  localparam int EXE_MEM_PAYLOAD_W = $bits(exe_mem_payload_t);

endpackage

// File: rtl/pipe_skid_buffer.sv
// pipe_skid_buffer
//   Generic valid/ready pipeline register for an opaque payload.
//   SKID_EN = 1 : two entries (main + skid); in_ready comes straight from a flop
//                 (skid empty), so there is no combinational out_ready -> in_ready path.
//   SKID_EN = 0 : single entry; in_ready = out_ready | ~out_valid.
// Ports
//   clk, rst (async, active-low), flush (sync, drops all entries and any concurrent input)
//   in_valid / in_ready / in_data    : upstream side
//   out_valid / out_ready / out_data : downstream side, out_data holds when invalid
module pipe_skid_buffer #(
  parameter int WIDTH   = 8,
  parameter bit SKID_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             main_valid;
  logic [WIDTH-1:0] main_data;
  logic             in_fire;
  logic             out_fire;

  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = main_valid & out_ready;

  generate
    if (SKID_EN) begin : g_skid
      logic             skid_valid;
      logic [WIDTH-1:0] skid_data;

      // The skid entry is only ever filled while main is full, so "skid empty"
      // is exactly "room for one more".
      assign in_ready = ~skid_valid;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          main_valid <= 1'b0;
          main_data  <= '0;
          skid_valid <= 1'b0;
          skid_data  <= '0;
        end else if (flush) begin
          main_valid <= 1'b0;
          skid_valid <= 1'b0;
        end else if (skid_valid) begin
          // in_ready is low here, so only the skid -> main move can happen
          if (out_fire) begin
            main_data  <= skid_data;
            skid_valid <= 1'b0;
          end
        end else if (in_fire) begin
          if (!main_valid || out_fire) begin
            main_valid <= 1'b1;
            main_data  <= in_data;
          end else begin
            skid_valid <= 1'b1;
            skid_data  <= in_data;
          end
        end else if (out_fire) begin
          main_valid <= 1'b0;
        end
      end
    end else begin : g_single
      assign in_ready = out_ready | ~main_valid;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          main_valid <= 1'b0;
          main_data  <= '0;
        end else if (flush) begin
          main_valid <= 1'b0;
        end else if (in_fire) begin
          main_valid <= 1'b1;
          main_data  <= in_data;
        end else if (out_fire) begin
          main_valid <= 1'b0;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/exe_mem_stage_reg.sv
// exe_mem_stage_reg
//   EXE->MEM stage register with valid/ready handshake so a slow data memory can
//   stall EXE without losing or duplicating instructions.
//   Build option: define EXE_MEM_SKID_EN for a two-entry skid buffer with a
//   registered in_ready; otherwise a single entry with combinational in_ready.
// Ports
//   clk, rst (async, active-low), flush (sync, branch taken)
//   in_valid/in_ready, in_wb_en, in_mem_r_en, in_mem_w_en, in_alu_res, in_val_rm, in_dest
//   out_valid/out_ready, out_wb_en, out_mem_r_en, out_mem_w_en, out_alu_res, out_val_rm, out_dest
//   Control outputs are forced low while out_valid = 0; data outputs hold.
import arm_pipe_pkg::*;

module exe_mem_stage_reg (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_wb_en,
  input  logic                   in_mem_r_en,
  input  logic                   in_mem_w_en,
  input  logic [WORD_LENGTH-1:0] in_alu_res,
  input  logic [WORD_LENGTH-1:0] in_val_rm,
  input  logic [REG_ADDR_W-1:0]  in_dest,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_wb_en,
  output logic                   out_mem_r_en,
  output logic                   out_mem_w_en,
  output logic [WORD_LENGTH-1:0] out_alu_res,
  output logic [WORD_LENGTH-1:0] out_val_rm,
  output logic [REG_ADDR_W-1:0]  out_dest
);

`ifdef EXE_MEM_SKID_EN
  localparam bit SKID_EN = 1'b1;
`else
  localparam bit SKID_EN = 1'b0;
`endif

  exe_mem_payload_t pl_in;
  exe_mem_payload_t pl_out;

  always_comb begin
    pl_in          = '0;
    pl_in.wb_en    = in_wb_en;
    pl_in.mem_r_en = in_mem_r_en;
    pl_in.mem_w_en = in_mem_w_en;
    pl_in.alu_res  = in_alu_res;
    pl_in.val_rm   = in_val_rm;
    pl_in.dest     = in_dest;
  end

  pipe_skid_buffer #(
    .WIDTH   (EXE_MEM_PAYLOAD_W),
    .SKID_EN (SKID_EN)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (pl_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (pl_out)
  );

  // A stale entry must never trigger a write-back or memory access in MEM.
  assign out_wb_en    = pl_out.wb_en    & out_valid;
  assign out_mem_r_en = pl_out.mem_r_en & out_valid;
  assign out_mem_w_en = pl_out.mem_w_en & out_valid;
  assign out_alu_res  = pl_out.alu_res;
  assign out_val_rm   = pl_out.val_rm;
  assign out_dest     = pl_out.dest;

endmodule
